// File: rtl/axi_write_master_ot.sv
// AXI4 write-channel master with registered AW/W/B slices, automatic WLAST
// generation, rolling AWID and up to MAX_OUT outstanding bursts.
// A small length FIFO carries each accepted burst length from the AW side
// to the W side, so data is never issued ahead of its command.
module axi_write_master_ot #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IDW     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  // user command
  input  logic [AW-1:0]                awaddr_in,
  input  logic [7:0]                   awlen_in,
  input  logic [2:0]                   awsize_in,
  input  logic [1:0]                   awburst_in,
  input  logic                         awvalid_in,
  output logic                         aw_cmd_ready,
  // user data
  input  logic [DW-1:0]                wdata_in,
  input  logic [DW/8-1:0]              wstrb_in,
  input  logic                         wvalid_in,
  output logic                         w_cmd_ready,
  // user response
  input  logic                         bready_in,
  output logic                         bvalid_out,
  output logic [1:0]                   bresp_out,
  output logic [IDW-1:0]               bid_out,
  // AXI AW
  output logic [IDW-1:0]               axi_awid,
  output logic [AW-1:0]                axi_awaddr,
  output logic [7:0]                   axi_awlen,
  output logic [2:0]                   axi_awsize,
  output logic [1:0]                   axi_awburst,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  // AXI W
  output logic [DW-1:0]                axi_wdata,
  output logic [DW/8-1:0]              axi_wstrb,
  output logic                         axi_wlast,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,
  // AXI B
  input  logic [IDW-1:0]               axi_bid,
  input  logic [1:0]                   axi_bresp,
  input  logic                         axi_bvalid,
  output logic                         axi_bready,
  // status
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         err_sticky
);

  localparam int          OW     = $clog2(MAX_OUT + 1);
  localparam int          PW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [2:0]  SZ_MAX = 3'($clog2(DW / 8));

  // AW slice
  logic [IDW-1:0] awid_q, awid_d, id_cnt_q, id_cnt_d;
  logic [AW-1:0]  awaddr_q, awaddr_d;
  logic [7:0]     awlen_q, awlen_d;
  logic [2:0]     awsize_q, awsize_d;
  logic [1:0]     awburst_q, awburst_d;
  logic           awvalid_q, awvalid_d;
  // W slice
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            wlast_q, wlast_d, wvalid_q, wvalid_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  // B slice
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [IDW-1:0] bid_q, bid_d;
  // length FIFO and status
  logic [7:0]     len_mem [MAX_OUT];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_ptr;
  logic [OW-1:0]  fifo_cnt_q, fifo_cnt_d, out_q, out_d;
  logic           err_q, err_d;

  logic cmd_acc, w_pop, w_avail, beat_acc, beat_last, b_stray, b_acc, b_ret;
  logic [7:0] head_len;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode. When the current WLAST beat leaves this cycle, the W
  // side looks one FIFO entry ahead so back-to-back bursts carry no bubble.
  assign aw_cmd_ready = (!awvalid_q | axi_awready) & (out_q < OW'(MAX_OUT))
                        & (fifo_cnt_q != OW'(MAX_OUT));
  assign cmd_acc      = awvalid_in & aw_cmd_ready;
  assign w_pop        = wvalid_q & axi_wready & wlast_q;
  assign head_ptr     = w_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign w_avail      = w_pop ? (fifo_cnt_q > OW'(1)) : (fifo_cnt_q != '0);
  assign head_len     = len_mem[head_ptr];
  assign w_cmd_ready  = w_avail & (!wvalid_q | axi_wready);
  assign beat_acc     = wvalid_in & w_cmd_ready;
  assign beat_last    = (beat_cnt_q == head_len);
  // A response with nothing outstanding is swallowed: bready stays high.
  assign b_stray      = axi_bvalid & (out_q == '0);
  assign axi_bready   = (out_q == '0) | !bvalid_q | bready_in;
  assign b_acc        = axi_bvalid & axi_bready & !b_stray;
  assign b_ret        = bvalid_q & bready_in;

  // Next-state logic for all three slices, the FIFO pointers and status.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    awid_d     = awid_q;     awaddr_d  = awaddr_q;  awlen_d    = awlen_q;
    awsize_d   = awsize_q;   awburst_d = awburst_q; awvalid_d  = awvalid_q;
    id_cnt_d   = id_cnt_q;
    wdata_d    = wdata_q;    wstrb_d   = wstrb_q;   wlast_d    = wlast_q;
    wvalid_d   = wvalid_q;   beat_cnt_d = beat_cnt_q;
    bvalid_d   = bvalid_q;   bresp_d   = bresp_q;   bid_d      = bid_q;
    wr_ptr_d   = wr_ptr_q;   rd_ptr_d  = rd_ptr_q;  fifo_cnt_d = fifo_cnt_q;
    out_d      = out_q;      err_d     = err_q;

    if (awvalid_q && axi_awready) awvalid_d = 1'b0;
    if (cmd_acc) begin
      awvalid_d = 1'b1;
      awid_d    = id_cnt_q;
      awaddr_d  = awaddr_in;
      awlen_d   = awlen_in;
      awsize_d  = awsize_in;
      awburst_d = awburst_in;
      id_cnt_d  = id_cnt_q + 1'b1;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end

    if (wvalid_q && axi_wready) wvalid_d = 1'b0;
    if (w_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (beat_acc) begin
      wvalid_d   = 1'b1;
      wdata_d    = wdata_in;
      wstrb_d    = wstrb_in;
      wlast_d    = beat_last;
      // The counter restarts once the last beat of a burst is taken.
      beat_cnt_d = beat_last ? 8'd0 : beat_cnt_q + 8'd1;
    end

    unique case ({cmd_acc, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (b_ret) bvalid_d = 1'b0;
    if (b_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = axi_bresp;
      bid_d    = axi_bid;
    end

    unique case ({cmd_acc, b_ret})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if ((b_acc && axi_bresp != 2'b00) || b_stray || (cmd_acc && awsize_in > SZ_MAX))
      err_d = 1'b1;
  end

  // State registers; reset abandons any partial burst immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awid_q   <= '0; awaddr_q  <= '0; awlen_q    <= '0; awsize_q <= '0;
      awburst_q <= '0; awvalid_q <= 1'b0; id_cnt_q <= '0;
      wdata_q  <= '0; wstrb_q   <= '0; wlast_q    <= 1'b0; wvalid_q <= 1'b0;
      beat_cnt_q <= '0;
      bvalid_q <= 1'b0; bresp_q <= '0; bid_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q  <= '0; fifo_cnt_q <= '0;
      out_q    <= '0; err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      awid_q   <= awid_d; awaddr_q  <= awaddr_d; awlen_q    <= awlen_d;
      awsize_q <= awsize_d; awburst_q <= awburst_d; awvalid_q <= awvalid_d;
      id_cnt_q <= id_cnt_d;
      wdata_q  <= wdata_d; wstrb_q   <= wstrb_d; wlast_q    <= wlast_d;
      wvalid_q <= wvalid_d; beat_cnt_q <= beat_cnt_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d; bid_q <= bid_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q  <= rd_ptr_d; fifo_cnt_q <= fifo_cnt_d;
      out_q    <= out_d; err_q     <= err_d;
    end
  end

  // Length FIFO storage written on command acceptance.
  // NOTE: the storage array has no reset; the reset pointers and count make
  // every entry unreadable until it has been written again.
  always_ff @(posedge clk) begin
    if (cmd_acc) len_mem[wr_ptr_q] <= awlen_in;
  end

  assign axi_awid    = awid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = awsize_q;
  assign axi_awburst = awburst_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = wlast_q;
  assign axi_wvalid  = wvalid_q;
  assign bvalid_out  = bvalid_q;
  assign bresp_out   = bresp_q;
  assign bid_out     = bid_q;
  assign outstanding = out_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_axi_write_master_ot.sv
// Directed bench for axi_write_master_ot (default parameters). Expected AW
// commands, W beats and user responses are queued when the stimulus is
// driven and compared whenever the DUT presents them on its outputs.
module tb_axi_write_master_ot;

  logic        clk, resetn;
  logic [31:0] awaddr_in;
  logic [7:0]  awlen_in;
  logic [2:0]  awsize_in;
  logic [1:0]  awburst_in;
  logic        awvalid_in, aw_cmd_ready;
  logic [63:0] wdata_in;
  logic [7:0]  wstrb_in;
  logic        wvalid_in, w_cmd_ready;
  logic        bready_in, bvalid_out;
  logic [1:0]  bresp_out;
  logic [3:0]  bid_out;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [2:0]  outstanding;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;
  int stall_cycles = 0;
  logic [3:0]  exp_id = '0;
  logic [48:0] aw_q[$];
  logic [72:0] w_q[$];
  logic [5:0]  b_q[$];

  axi_write_master_ot dut (
    .clk(clk), .resetn(resetn),
    .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in),
    .awburst_in(awburst_in), .awvalid_in(awvalid_in), .aw_cmd_ready(aw_cmd_ready),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in),
    .w_cmd_ready(w_cmd_ready),
    .bready_in(bready_in), .bvalid_out(bvalid_out), .bresp_out(bresp_out),
    .bid_out(bid_out),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .outstanding(outstanding), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: whatever the DUT presents must match the queue head;
  // the head is retired only when the handshake completes at the next edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (axi_awvalid) begin
        if (aw_q.size() == 0) check("aw_unexpected", axi_awvalid, 1'b0);
        else begin
          check("aw", {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst}, aw_q[0]);
          if (axi_awready) void'(aw_q.pop_front());
        end
      end
      if (axi_wvalid) begin
        if (w_q.size() == 0) check("w_unexpected", axi_wvalid, 1'b0);
        else begin
          check("w", {axi_wdata, axi_wstrb, axi_wlast}, w_q[0]);
          if (axi_wready) void'(w_q.pop_front());
        end
      end
      if (bvalid_out) begin
        if (b_q.size() == 0) check("b_unexpected", bvalid_out, 1'b0);
        else begin
          check("b", {bid_out, bresp_out}, b_q[0]);
          if (bready_in) void'(b_q.pop_front());
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    awaddr_in = addr; awlen_in = len; awsize_in = size; awburst_in = 2'b01;
    awvalid_in = 1'b1;
    do begin @(negedge clk); n++; end while (!aw_cmd_ready && n < 200);
    check("cmd_accept", aw_cmd_ready, 1'b1);
    @(posedge clk); #1;
    awvalid_in = 1'b0;
    aw_q.push_back({exp_id, addr, len, size, 2'b01});
    exp_id = exp_id + 1'b1;
  endtask

  task automatic send_beats(input int n_beats, input int len);
    logic [63:0] d;
    logic [7:0]  s;
    int n;
    for (int i = 0; i < n_beats; i++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      wdata_in = d; wstrb_in = s; wvalid_in = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_cmd_ready && n < 200);
      stall_cycles += n - 1;
      check("beat_accept", w_cmd_ready, 1'b1);
      @(posedge clk); #1;
      w_q.push_back({d, s, 1'(i == len)});
    end
    wvalid_in = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    axi_bid = id; axi_bresp = resp; axi_bvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!axi_bready && n < 200);
    check("b_accept", axi_bready, 1'b1);
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    b_q.push_back({id, resp});
    check("bvalid_latency", bvalid_out, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((aw_q.size() + w_q.size() + b_q.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain", aw_q.size() + w_q.size() + b_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_bvalid", bvalid_out, 1'b0);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_err", err_sticky, 1'b0);
    aw_q.delete(); w_q.delete(); b_q.delete();
    exp_id = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awvalid", axi_awvalid, 1'b0);
    check("post_rst_wvalid", axi_wvalid, 1'b0);
  endtask

  initial begin
    logic [3:0] id0;
    resetn = 1'b0;
    awaddr_in = '0; awlen_in = '0; awsize_in = '0; awburst_in = '0; awvalid_in = 1'b0;
    wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0;
    bready_in = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_awvalid", axi_awvalid, 1'b0);
    check("reset_awid", axi_awid, 4'd0);
    check("reset_wvalid", axi_wvalid, 1'b0);
    check("reset_wlast", axi_wlast, 1'b0);
    check("reset_bvalid", bvalid_out, 1'b0);
    check("reset_outstanding", outstanding, 3'd0);
    check("reset_err", err_sticky, 1'b0);
    check("reset_w_ready", w_cmd_ready, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single burst, awlen=3, full-width beats, OKAY response.
    send_cmd(32'h0000_1000, 8'd3, 3'd3);
    check("single_out_1", outstanding, 3'd1);
    stall_cycles = 0;
    send_beats(4, 3);
    wait_drain();
    send_b(4'd0, 2'b00);
    check("single_out_still_1", outstanding, 3'd1);
    @(posedge clk); #1;
    check("single_out_0", outstanding, 3'd0);
    check("single_err", err_sticky, 1'b0);

    // Outstanding limit: four single-beat bursts fill the tracker.
    for (int i = 0; i < 4; i++) send_cmd(32'h2000 + 32'(i * 8), 8'd0, 3'd3);
    check("full_out_4", outstanding, 3'd4);
    check("full_cmd_ready", aw_cmd_ready, 1'b0);
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) send_beats(1, 0);
    check("b2b_no_bubble", stall_cycles, 0);
    wait_drain();
    fork
      send_cmd(32'h2100, 8'd0, 3'd3);
      begin
        @(negedge clk);
        check("full_blocks_5th", aw_cmd_ready, 1'b0);
        @(posedge clk); #1;
        send_b(4'd1, 2'b00);
      end
    join
    send_beats(1, 0);
    wait_drain();
    for (int i = 2; i <= 5; i++) send_b(4'(i), 2'b00);
    wait_drain();
    check("full_out_0", outstanding, 3'd0);

    // AWID rolls over: 17 bursts cross the 15 -> 0 boundary.
    for (int i = 0; i < 17; i++) begin
      id0 = exp_id;
      send_cmd(32'h4000 + 32'(i * 64), 8'd0, 3'd3);
      send_beats(1, 0);
      wait_drain();
      send_b(id0, 2'b00);
    end
    wait_drain();
    check("wrap_out_0", outstanding, 3'd0);

    // Backpressure: AW and W held off, outputs must stay put.
    axi_awready = 1'b0; axi_wready = 1'b0;
    id0 = exp_id;
    fork
      send_cmd(32'h8000, 8'd2, 3'd2);
      send_beats(3, 2);
      begin
        repeat (4) @(negedge clk);
        check("stall_aw_held", axi_awvalid, 1'b1);
        check("stall_w_held", axi_wvalid, 1'b1);
        @(posedge clk); #1;
        axi_awready = 1'b1; axi_wready = 1'b1;
      end
    join
    wait_drain();
    send_b(id0, 2'b00);
    wait_drain();

    // SLVERR response propagates and latches the sticky error.
    id0 = exp_id;
    send_cmd(32'h9000, 8'd0, 3'd3);
    send_beats(1, 0);
    wait_drain();
    check("err_before", err_sticky, 1'b0);
    send_b(id0, 2'b10);
    check("err_set", err_sticky, 1'b1);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_held", err_sticky, 1'b1);

    // Reset during beat 2 of an 8-beat burst, then a clean burst restarts at ID 0.
    send_cmd(32'hA000, 8'd7, 3'd3);
    send_beats(2, 7);
    pulse_reset();
    send_cmd(32'hB000, 8'd7, 3'd3);
    send_beats(8, 7);
    wait_drain();
    send_b(4'd0, 2'b00);
    wait_drain();
    check("post_rst_out_0", outstanding, 3'd0);

    // Oversized beat: command still issued unchanged but flagged.
    send_cmd(32'hC000, 8'd0, 3'd4);
    check("awsize_err", err_sticky, 1'b1);
    send_beats(1, 0);
    wait_drain();
    send_b(4'd1, 2'b00);
    wait_drain();

    // Response with nothing outstanding is dropped and flagged.
    pulse_reset();
    axi_bid = 4'd3; axi_bresp = 2'b00; axi_bvalid = 1'b1;
    @(negedge clk);
    check("stray_bready", axi_bready, 1'b1);
    @(posedge clk); #1;
    axi_bvalid = 1'b0;
    check("stray_dropped", bvalid_out, 1'b0);
    check("stray_err", err_sticky, 1'b1);
    check("stray_out_0", outstanding, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
